output_register_bank: RTL
=========================

// Module: output_register_bank
// PURPOSE
//  Parametrised output register file with a self-draining streaming port.
//  - The core writes results by index, as the CPU's existing output store does.
//  - A per-slot dirty bitmap tracks slots written but not yet drained.
//  - A round-robin scanner presents dirty slots to external logic over a valid/ready handshake.
//  - A separate registered random-access read port is provided for debug/host reads.
// PARAMETERS
//  DATA_W   16               slot width in bits
//  DEPTH    32               number of slots; power of two, >= 2
//  IDX_W    $clog2(DEPTH)    index width (derived; do not override)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  wr_en        in   1        write strobe from accumulator path
//  wr_idx       in   IDX_W    write slot index
//  wr_data      in   DATA_W   write value (accumulator)
//  rd_en        in   1        random-access read strobe
//  rd_idx       in   IDX_W    read slot index
//  rd_data      out  DATA_W   registered read data
//  clear_all    in   1        discard all pending (dirty) slots
//  out_valid    out  1        drain port: slot presented
//  out_ready    in   1        drain port: consumer accepts
//  out_idx      out  IDX_W    index of presented slot
//  out_data     out  DATA_W   value of presented slot
//  dirty_count  out  IDX_W+1  number of dirty slots (registered)
// BEHAVIOUR
//  Reset:
//  - dirty bitmap and scan ptr are 0; FSM is IDLE.
//  - out_valid, out_idx, out_data, rd_data and dirty_count are 0.
//  - Slot storage is not reset.
//  Priority: rst > clear_all > wr_en.
//  Write: on wr_en, mem[wr_idx] <= wr_data and dirty[wr_idx] <= 1 at the same edge.
//  Read:
//  - On rd_en, rd_data <= mem[rd_idx], with 1-cycle latency; rd_data holds while rd_en=0.
//  - Same-cycle write and read of the same index returns the OLD value (read-before-write).
//  FSM IDLE:
//  - If any dirty bit is set, select the first dirty index at or after ptr, wrapping at DEPTH-1 -> 0.
//  - Register out_idx/out_data from that slot, set out_valid=1 and go to PRESENT.
//  - Otherwise stay in IDLE.
//  FSM PRESENT:
//  - out_valid=1; out_idx and out_data are held stable until handshake, even if that slot is rewritten.
//  - Handshake (out_valid & out_ready):
//    - Clear dirty[out_idx], unless the slot was rewritten while presented, including in the handshake cycle.
//    - A rewritten slot stays dirty and is re-presented later with its new value.
//    - ptr <= out_idx+1 (mod DEPTH); out_valid <= 0; return to IDLE.
//  Latency and throughput:
//  - A write in cycle N gives the earliest out_valid in cycle N+2.
//  - After a handshake in cycle M, the next presentation is in cycle M+2 (one bubble).
//  - Sustained drain rate is one slot per 2 cycles.
//  clear_all:
//  - All dirty bits are cleared; FSM goes to IDLE; out_valid is 0 next cycle, even mid-presentation.
//  - ptr and slot data are unchanged.
//  - A wr_en in the same cycle is stored to memory, but its dirty bit is NOT set.
//  rst mid-presentation: out_valid drops next cycle and pending slots are lost.
//  dirty_count:
//  - Registered popcount of the dirty bitmap, updated one cycle after the bitmap changes.
//  - Range 0..DEPTH; equals DEPTH when all slots are dirty.
//  Full case: all slots dirty -> drains in strict index order starting from ptr.
//  Writes never stall; a rewrite of a dirty slot overwrites the undrained value.
// CONFIGURATION
//  OUTREG_OVF_CNT_EN defined:
//  - Adds output port ovf_count [7:0], a saturating count (sticks at 255) of writes to already-dirty slots.
//  - This includes the presented slot.
//  - Reset to 0 by rst only; clear_all does not reset it.
//  OUTREG_OVF_CNT_EN undefined: port and counter are absent, and behaviour is otherwise identical.
// TESTING
//  1 Reset: assert rst for 2 cycles -> out_valid=0, rd_data=0, dirty_count=0.
//  2 Single drain:
//    - Stimulus: write idx 5 = 0x1234 in cycle N, out_ready=1.
//    - Response: out_valid in N+2 with out_idx=5, out_data=0x1234; dirty_count 1 -> 0 after handshake.
//  3 Round-robin wrap:
//    - Stimulus: DEPTH=32, ptr=30 (drain idx 29 first), then write idx 31, 2, 30.
//    - Response: drain order is 30, 31, 2.
//  4 Backpressure rewrite:
//    - Stimulus: present idx 7 = 0x0001 with out_ready=0, write idx 7 = 0x0002, then raise out_ready.
//    - Response: first handshake carries 0x0001 (held stable); idx 7 is re-presented with 0x0002.
//  5 clear_all mid-presentation:
//    - Stimulus: 3 slots dirty, out_valid=1, pulse clear_all.
//    - Response: out_valid=0 next cycle, dirty_count=0 within 2 cycles; rd of those slots still returns the data.
//  6 Read-before-write:
//    - Stimulus: same-cycle wr idx 3 = 0xBEEF and rd idx 3 (old 0xAAAA).
//    - Response: rd_data=0xAAAA, then a later read gives 0xBEEF.
//    - With OUTREG_OVF_CNT_EN: 300 rewrites of a dirty slot -> ovf_count=255.

Source files
------------

// File: rtl/output_register_bank.sv
// rtl/output_register_bank.sv - indexed output register file with a round-robin dirty-slot drain port
// Optional feature: define OUTREG_OVF_CNT_EN to add ovf_count (saturating count of writes to dirty slots).
module output_register_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clear_all,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W:0]    dirty_count
`ifdef OUTREG_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_count
`endif
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  dirty, dirty_next;
  logic [IDX_W-1:0]  ptr;
  logic              rewritten;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W:0]    pop;
  logic              handshake, load, wr_hit_out;

  // Descending scan so the lowest offset from ptr wins; index arithmetic wraps at DEPTH.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx = ptr + IDX_W'(i);
      if (dirty[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop = pop + (IDX_W+1)'(dirty[i]);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = PRESENT;
      PRESENT: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_all) state_next = IDLE;
  end

  assign handshake  = (state == PRESENT) && out_ready && !clear_all;
  assign load       = (state == IDLE) && found && !clear_all;
  assign wr_hit_out = wr_en && (wr_idx == out_idx);

  // A slot rewritten while presented keeps its dirty bit so the new value drains later.
  always_comb begin
    dirty_next = dirty;
    if (clear_all) begin
      dirty_next = '0;
    end else begin
      if (handshake && !(rewritten || wr_hit_out)) dirty_next[out_idx] = 1'b0;
      if (wr_en) dirty_next[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty       <= '0;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      rd_data     <= '0;
      dirty_count <= '0;
      rewritten   <= 1'b0;
    end else begin
      if (rd_en) rd_data <= mem[rd_idx];
      dirty_count <= pop;
      dirty       <= dirty_next;
      out_valid   <= (state_next == PRESENT);
      if (load) begin
        out_idx   <= sel_idx;
        out_data  <= mem[sel_idx];
        rewritten <= wr_en && (wr_idx == sel_idx);
      end else if ((state == PRESENT) && wr_hit_out) begin
        rewritten <= 1'b1;
      end
      if (handshake) ptr <= out_idx + IDX_W'(1);
    end
  end

`ifdef OUTREG_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (wr_en && dirty[wr_idx] && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule
